// File: rtl/codec_i2c_arbiter_pkg.sv
// Shared types and constants for the codec I2C command arbiter.
package codec_i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_XFER,
    S_FINISH,
    S_ABORT
  } state_t;

  localparam int CMD_W       = 16;
  localparam int TIMEOUT_DEF = 1024;

  // Index width for a one-hot vector of n entries; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/codec_i2c_arbiter_if.sv
// Requester-side and I2C-master-side signals of the arbiter.
interface codec_i2c_arbiter_if
  import codec_i2c_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = CMD_W
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                start;
  logic [DW-1:0]       data;
  logic                busy;
  logic                idle;

  // slave: the arbiter itself
  modport slave (
    input  req, wdata, busy,
    output grant, done, err, start, data, idle
  );

  // master: command sources plus the I2C master
  modport master (
    output req, wdata, busy,
    input  grant, done, err, start, data, idle
  );
endinterface

// File: rtl/codec_i2c_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted req at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] cand;

  always_comb begin
    win  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!vld && req[cand]) begin
        win[cand] = 1'b1;
        idx       = cand;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/codec_i2c_arbiter.sv
// Round-robin owner of the shared codec I2C master: launches a latched command,
// waits for busy to rise and fall, and returns a done or timeout err pulse.
module codec_i2c_arbiter
  import codec_i2c_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int DW      = CMD_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK_50,
  input  logic               RST,
  codec_i2c_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  state_t                    state;
  logic [IW-1:0]             ptr;
  logic [IW-1:0]             owner;
  logic [CW-1:0]             cnt;
  logic [N_REQ-1:0]          grant_r;
  logic [N_REQ-1:0]          done_r;
  logic [N_REQ-1:0]          err_r;
  logic                      start_r;
  logic [DW-1:0]             data_r;
  logic                      idle_r;

  logic [N_REQ-1:0][DW-1:0]  wvec;
  logic [N_REQ-1:0]          pick_oh;
  logic [IW-1:0]             pick_idx;
  logic                      pick_vld;
  logic [IW-1:0]             ptr_nxt;

  assign wvec    = bus.wdata;
  assign ptr_nxt = (owner == IDX_LAST) ? '0 : owner + 1'b1;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .win (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state   <= S_IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      grant_r <= '0;
      done_r  <= '0;
      err_r   <= '0;
      start_r <= 1'b0;
      data_r  <= '0;
      idle_r  <= 1'b1;
    end else begin
      done_r <= '0;
      err_r  <= '0;
      unique case (state)
        S_IDLE: begin
          // The master may still be finishing a transfer it owns outside our view.
          if (pick_vld && !bus.busy) begin
            owner   <= pick_idx;
            grant_r <= pick_oh;
            data_r  <= wvec[pick_idx];
            start_r <= 1'b1;
            cnt     <= '0;
            idle_r  <= 1'b0;
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (bus.busy) begin
            start_r <= 1'b0;
            state   <= S_XFER;
          end else if (cnt == CNT_LAST) begin
            start_r <= 1'b0;
            state   <= S_ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          // No timeout here: the master owns the transfer length once busy rose.
          if (!bus.busy) begin
            done_r  <= grant_r;
            grant_r <= '0;
            ptr     <= ptr_nxt;
            state   <= S_FINISH;
          end
        end
        S_FINISH: begin
          idle_r <= 1'b1;
          state  <= S_IDLE;
        end
        S_ABORT: begin
          err_r   <= grant_r;
          grant_r <= '0;
          ptr     <= ptr_nxt;
          idle_r  <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant = grant_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.start = start_r;
  assign bus.data  = data_r;
  assign bus.idle  = idle_r;

endmodule
